// File: rtl/idecode_pipe.sv
// -----------------------------------------------------------------------------
// idecode_pipe -- pipelined decode stage.
//
// Contents:
//   - a 2-read / 1-write register file (x0 reads as zero)
//   - an immediate extender
//   - operand forwarding
//   - load-use hazard detection
//   - an ID/EX pipeline register with a valid/ready handshake and flush
//
// Optional feature:
//   IDECODE_FWD_EN
//     Defined: EX and MEM results are forwarded into the operands, so only a
//     load in EX stalls a dependent instruction.
//     Undefined: only the WB write-first bypass exists, and any valid EX or
//     MEM producer of a source register stalls the decode.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   id_valid/id_ready     IF/ID -> ID handshake
//   id_pc, id_inst        decoded instruction and its PC
//   id_sext_op            immediate format (0:I 1:S 2:B 3:U 4:J)
//   id_ctrl               opaque controller bundle, carried into ID/EX
//   flush                 kill the ID instruction and the ID/EX contents
//   ex_is_load, ex_rf_we, ex_rd, ex_alu_c   EX-stage producer info
//   mem_rf_we, mem_rd, mem_wdata            MEM-stage producer info
//   wb_we, wb_wsel, wb_wr, wb_alu_c, wb_mem_data, wb_ext, wb_pc4
//                         register-file write port and write-data candidates
//   ex_valid/ex_ready     ID/EX -> EX handshake
//   ex_pc, ex_rd1, ex_rd2, ex_ext, ex_rs1, ex_rs2, ex_rdst, ex_ctrl
//                         registered ID/EX payload
// -----------------------------------------------------------------------------

// Operand select for one read port.
// Priority: x0 -> EX -> MEM -> WB -> register file.
module idecode_opsel #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   idx,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_fwd,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_fwd,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_fwd,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op
);
  always_comb begin
    op = rf_data;
    if (idx == '0)                      op = '0;
    else if (ex_fwd  && ex_rd  == idx)  op = ex_data;
    else if (mem_fwd && mem_rd == idx)  op = mem_data;
    else if (wb_fwd  && wb_rd  == idx)  op = wb_data;
  end
endmodule

module idecode_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int CTRL_W = 16,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [31:0]       id_inst,
  input  logic [2:0]        id_sext_op,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ex_is_load,
  input  logic              ex_rf_we,
  input  logic [AW-1:0]     ex_rd,
  input  logic [XLEN-1:0]   ex_alu_c,
  input  logic              mem_rf_we,
  input  logic [AW-1:0]     mem_rd,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              wb_we,
  input  logic [1:0]        wb_wsel,
  input  logic [AW-1:0]     wb_wr,
  input  logic [XLEN-1:0]   wb_alu_c,
  input  logic [XLEN-1:0]   wb_mem_data,
  input  logic [XLEN-1:0]   wb_ext,
  input  logic [XLEN-1:0]   wb_pc4,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_ext,
  output logic [AW-1:0]     ex_rs1,
  output logic [AW-1:0]     ex_rs2,
  output logic [AW-1:0]     ex_rdst,
  output logic [CTRL_W-1:0] ex_ctrl
);

`ifdef IDECODE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   ext;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic [AW-1:0]     rdst;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  idex_t idex_d, idex_q;
  logic  ex_vld_q;

  // Decode fields.
  logic [1:0][AW-1:0]   rs_idx;
  logic [1:0][XLEN-1:0] op;
  logic [AW-1:0]        rdst;

  assign rs_idx[0] = id_inst[15 +: AW];
  assign rs_idx[1] = id_inst[20 +: AW];
  assign rdst      = id_inst[7 +: AW];

  // Only some instruction bits feed the datapath (opcode/funct are
  // decoded upstream into id_ctrl).
  logic unused_inst;
  assign unused_inst = ^id_inst;

  // WB write data.
  logic [XLEN-1:0] wd;

  always_comb begin
    wd = wb_alu_c;
    case (wb_wsel)
      2'd0: wd = wb_alu_c;
      2'd1: wd = wb_mem_data;
      2'd2: wd = wb_ext;
      2'd3: wd = wb_pc4;
      default: wd = wb_alu_c;
    endcase
  end

  // Register file. Entry 0 is never written, so it stays at its reset
  // value of zero.
  logic [XLEN-1:0] rf [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && wb_wr != '0) begin
      rf[wb_wr] <= wd;
    end
  end

  // Forwarding enables. A load in EX has no data yet, so it never forwards.
  logic ex_fwd, mem_fwd;

  assign ex_fwd  = FWD & ex_vld_q & ex_rf_we & ~ex_is_load;
  assign mem_fwd = FWD & mem_rf_we;

  for (genvar p = 0; p < 2; p++) begin : g_port
    idecode_opsel #(.XLEN(XLEN), .AW(AW)) u_opsel (
      .idx      (rs_idx[p]),
      .rf_data  (rf[rs_idx[p]]),
      .ex_fwd   (ex_fwd),
      .ex_rd    (ex_rd),
      .ex_data  (ex_alu_c),
      .mem_fwd  (mem_fwd),
      .mem_rd   (mem_rd),
      .mem_data (mem_wdata),
      .wb_fwd   (wb_we),
      .wb_rd    (wb_wr),
      .wb_data  (wd),
      .op       (op[p])
    );
  end

  // Immediate extender. The immediate is built at 32 bits, then sign-cast
  // to XLEN.
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (id_sext_op)
      3'd0: imm32 = {{20{id_inst[31]}}, id_inst[31:20]};
      3'd1: imm32 = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
      3'd2: imm32 = {{19{id_inst[31]}}, id_inst[31], id_inst[7],
                     id_inst[30:25], id_inst[11:8], 1'b0};
      3'd3: imm32 = {id_inst[31:12], 12'b0};
      3'd4: imm32 = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12],
                     id_inst[20], id_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Hazard detection. Both source fields are compared regardless of the
  // format; the occasional false stall is cheaper than decoding the format.
  logic ex_match, mem_match, hazard, adv;

  assign ex_match  = (ex_rd != '0) &&
                     (ex_rd == rs_idx[0] || ex_rd == rs_idx[1]);
  assign mem_match = (mem_rd != '0) &&
                     (mem_rd == rs_idx[0] || mem_rd == rs_idx[1]);

  assign hazard = FWD ? (ex_vld_q & ex_is_load & ex_rf_we & ex_match)
                      : ((ex_vld_q & ex_rf_we & ex_match) |
                         (mem_rf_we & mem_match));

  assign adv      = ~ex_vld_q | ex_ready;
  // A flushed ID instruction is dropped, never accepted.
  assign id_ready = ~flush & ~hazard & adv;

  always_comb begin
    idex_d      = '0;
    idex_d.pc   = id_pc;
    idex_d.rd1  = op[0];
    idex_d.rd2  = op[1];
    idex_d.ext  = XLEN'($signed(imm32));
    idex_d.rs1  = rs_idx[0];
    idex_d.rs2  = rs_idx[1];
    idex_d.rdst = rdst;
    idex_d.ctrl = id_ctrl;
  end

  // ID/EX register. Flush kills the valid bit but leaves the payload
  // as it was. On a hazard the stage still advances, inserting a bubble
  // (valid=0) ahead of the stalled instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld_q <= 1'b0;
      idex_q   <= '0;
    end else if (flush) begin
      ex_vld_q <= 1'b0;
    end else if (adv) begin
      ex_vld_q <= id_valid & ~hazard;
      idex_q   <= idex_d;
    end
  end

  assign ex_valid = ex_vld_q;
  assign ex_pc    = idex_q.pc;
  assign ex_rd1   = idex_q.rd1;
  assign ex_rd2   = idex_q.rd2;
  assign ex_ext   = idex_q.ext;
  assign ex_rs1   = idex_q.rs1;
  assign ex_rs2   = idex_q.rs2;
  assign ex_rdst  = idex_q.rdst;
  assign ex_ctrl  = idex_q.ctrl;

endmodule

// File: tb/tb_idecode_pipe.sv
// -----------------------------------------------------------------------------
// tb_idecode_pipe -- directed scenarios followed by randomized traffic.
// The reference model is a plain register array plus one ID/EX record,
// updated per cycle from the hazard / operand / immediate rules.
// -----------------------------------------------------------------------------
module tb_idecode_pipe;
  localparam int XLEN = 32, NREG = 32, AW = 5, CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [31:0]       id_inst;
  logic [2:0]        id_sext_op;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush, ex_is_load, ex_rf_we;
  logic [AW-1:0]     ex_rd;
  logic [XLEN-1:0]   ex_alu_c;
  logic              mem_rf_we;
  logic [AW-1:0]     mem_rd;
  logic [XLEN-1:0]   mem_wdata;
  logic              wb_we;
  logic [1:0]        wb_wsel;
  logic [AW-1:0]     wb_wr;
  logic [XLEN-1:0]   wb_alu_c, wb_mem_data, wb_ext, wb_pc4;
  logic              ex_valid, ex_ready;
  logic [XLEN-1:0]   ex_pc, ex_rd1, ex_rd2, ex_ext;
  logic [AW-1:0]     ex_rs1, ex_rs2, ex_rdst;
  logic [CTRL_W-1:0] ex_ctrl;

  always #5 clk = ~clk;

  idecode_pipe #(.XLEN(XLEN), .NREG(NREG), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst),
    .id_sext_op(id_sext_op), .id_ctrl(id_ctrl),
    .flush(flush), .ex_is_load(ex_is_load), .ex_rf_we(ex_rf_we),
    .ex_rd(ex_rd), .ex_alu_c(ex_alu_c),
    .mem_rf_we(mem_rf_we), .mem_rd(mem_rd), .mem_wdata(mem_wdata),
    .wb_we(wb_we), .wb_wsel(wb_wsel), .wb_wr(wb_wr),
    .wb_alu_c(wb_alu_c), .wb_mem_data(wb_mem_data),
    .wb_ext(wb_ext), .wb_pc4(wb_pc4),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_ext(ex_ext),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rdst(ex_rdst), .ex_ctrl(ex_ctrl)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] m_rf [NREG];
  bit          m_ev;
  logic [31:0] m_pc, m_rd1, m_rd2, m_ext;
  logic [4:0]  m_rs1, m_rs2, m_rdst;
  logic [15:0] m_ctrl;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    m_ev  = 0;
    m_pc  = '0; m_rd1 = '0; m_rd2 = '0; m_ext = '0;
    m_rs1 = '0; m_rs2 = '0; m_rdst = '0; m_ctrl = '0;
  endtask

  function automatic logic [31:0] f_ext(input logic [31:0] i,
                                        input logic [2:0] fmt);
    int b31 = i[31] ? -1 : 0;
    logic [31:0] r;
    case (fmt)
      3'd0:    r = (b31 << 12) | i[31:20];
      3'd1:    r = (b31 << 12) | (i[31:25] << 5) | i[11:7];
      3'd2:    r = (b31 << 12) | (i[7] << 11) | (i[30:25] << 5) | (i[11:8] << 1);
      3'd3:    r = i & 32'hFFFF_F000;
      3'd4:    r = (b31 << 20) | (i[19:12] << 12) | (i[20] << 11) | (i[30:21] << 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] f_wd();
    case (wb_wsel)
      2'd0:    return wb_alu_c;
      2'd1:    return wb_mem_data;
      2'd2:    return wb_ext;
      default: return wb_pc4;
    endcase
  endfunction

  function automatic logic [31:0] f_op(input logic [4:0] idx);
    if (idx == 0) return '0;
`ifdef IDECODE_FWD_EN
    if (m_ev && ex_rf_we && !ex_is_load && ex_rd == idx) return ex_alu_c;
    if (mem_rf_we && mem_rd == idx) return mem_wdata;
`endif
    if (wb_we && wb_wr == idx) return f_wd();
    return m_rf[idx];
  endfunction

  function automatic bit f_uses(input logic [4:0] r);
    return r != 0 && (r == id_inst[19:15] || r == id_inst[24:20]);
  endfunction

  function automatic bit f_hazard();
`ifdef IDECODE_FWD_EN
    return m_ev && ex_is_load && ex_rf_we && f_uses(ex_rd);
`else
    return (m_ev && ex_rf_we && f_uses(ex_rd)) || (mem_rf_we && f_uses(mem_rd));
`endif
  endfunction

  task automatic check_ex(input string tag);
    chk({tag, "_valid"}, ex_valid, m_ev);
    chk({tag, "_pc"},    ex_pc,    m_pc);
    chk({tag, "_rd1"},   ex_rd1,   m_rd1);
    chk({tag, "_rd2"},   ex_rd2,   m_rd2);
    chk({tag, "_ext"},   ex_ext,   m_ext);
    chk({tag, "_rs1"},   ex_rs1,   m_rs1);
    chk({tag, "_rs2"},   ex_rs2,   m_rs2);
    chk({tag, "_rdst"},  ex_rdst,  m_rdst);
    chk({tag, "_ctrl"},  ex_ctrl,  m_ctrl);
  endtask

  // One clock cycle. Entered at a negedge with inputs already driven,
  // and returns at the next negedge.
  task automatic tick();
    bit hz, adv;
    logic [31:0] o1, o2, wd;
    #1;
    hz  = f_hazard();
    adv = !m_ev || ex_ready;
    chk("id_ready", id_ready, !flush && !hz && adv);
    o1 = f_op(id_inst[19:15]);
    o2 = f_op(id_inst[24:20]);
    wd = f_wd();
    @(posedge clk);
    if (flush) begin
      m_ev = 0;
    end else if (adv) begin
      m_ev   = id_valid && !hz;
      m_pc   = id_pc;
      m_rd1  = o1;
      m_rd2  = o2;
      m_ext  = f_ext(id_inst, id_sext_op);
      m_rs1  = id_inst[19:15];
      m_rs2  = id_inst[24:20];
      m_rdst = id_inst[11:7];
      m_ctrl = id_ctrl;
    end
    if (wb_we && wb_wr != 0) m_rf[wb_wr] = wd;
    #1;
    check_ex("ex");
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_pc = '0; id_inst = '0; id_sext_op = '0; id_ctrl = '0;
    flush = 0; ex_is_load = 0; ex_rf_we = 0; ex_rd = '0; ex_alu_c = '0;
    mem_rf_we = 0; mem_rd = '0; mem_wdata = '0;
    wb_we = 0; wb_wsel = '0; wb_wr = '0;
    wb_alu_c = '0; wb_mem_data = '0; wb_ext = '0; wb_pc4 = '0;
    ex_ready = 1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b);
    logic [31:0] v = $urandom;
    v[19:15] = a;
    v[24:20] = b;
    return v;
  endfunction

  task automatic rand_in();
    id_valid    = $urandom_range(0, 3) != 0;
    id_pc       = $urandom;
    id_inst     = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    id_sext_op  = 3'($urandom_range(0, 7));
    id_ctrl     = 16'($urandom);
    flush       = $urandom_range(0, 15) == 0;
    ex_is_load  = $urandom_range(0, 2) == 0;
    ex_rf_we    = $urandom_range(0, 1) != 0;
    ex_rd       = 5'($urandom_range(0, 7));
    ex_alu_c    = $urandom;
    mem_rf_we   = $urandom_range(0, 2) == 0;
    mem_rd      = 5'($urandom_range(0, 7));
    mem_wdata   = $urandom;
    wb_we       = $urandom_range(0, 1) != 0;
    wb_wsel     = 2'($urandom_range(0, 3));
    wb_wr       = 5'($urandom_range(0, 7));
    wb_alu_c    = $urandom;
    wb_mem_data = $urandom;
    wb_ext      = $urandom;
    wb_pc4      = $urandom;
    ex_ready    = $urandom_range(0, 3) != 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_ex("rst");
    rst_n = 1;

    // WB write-first bypass: pc4 written to x5 while x5 is decoded.
    idle(); id_valid = 1; id_inst = mk(5, 0);
    wb_we = 1; wb_wsel = 3; wb_wr = 5; wb_pc4 = 32'h104;
    tick();
    chk("t2_rd1", ex_rd1, 32'h104);

    // B-format immediate.
    idle(); id_valid = 1; id_inst = 32'hFE01_0EE3; id_sext_op = 3'd2;
    tick();
    chk("t6_ext", ex_ext, 32'hFFFF_FFFC);

    // A write to x0 is ignored and x0 always reads as zero.
    idle(); id_valid = 1; id_inst = mk(0, 0);
    wb_we = 1; wb_wsel = 0; wb_wr = 0; wb_alu_c = 32'hFF;
    tick();
    chk("t6_x0_byp", ex_rd1, 32'h0);
    idle(); id_valid = 1; id_inst = mk(0, 0);
    tick();
    chk("t6_x0_rf", ex_rd1, 32'h0);

    // Load-use: lw x6 in EX, ID reads x6.
    idle(); id_valid = 1; id_inst = mk(6, 1);
    ex_is_load = 1; ex_rf_we = 1; ex_rd = 6;
    tick();
    chk("t3_bubble", ex_valid, 1'b0);
    idle(); id_valid = 1; id_inst = mk(6, 1);
    mem_rf_we = 1; mem_rd = 6; mem_wdata = 32'hDEAD;
    tick();
`ifndef IDECODE_FWD_EN
    idle(); id_valid = 1; id_inst = mk(6, 1);
    wb_we = 1; wb_wsel = 1; wb_wr = 6; wb_mem_data = 32'hDEAD;
    tick();
`endif
    chk("t3_rd1", ex_rd1, 32'hDEAD);

    // ALU producer in EX: addi x8, then ID reads x8 as rs2.
    idle(); id_valid = 1; id_inst = mk(0, 8);
    ex_rf_we = 1; ex_rd = 8; ex_alu_c = 32'h2A;
    tick();
`ifndef IDECODE_FWD_EN
    idle(); id_valid = 1; id_inst = mk(0, 8);
    mem_rf_we = 1; mem_rd = 8; mem_wdata = 32'h2A;
    tick();
    idle(); id_valid = 1; id_inst = mk(0, 8);
    wb_we = 1; wb_wsel = 0; wb_wr = 8; wb_alu_c = 32'h2A;
    tick();
`endif
    chk("t4_rd2", ex_rd2, 32'h2A);

    // Backpressure holds ID/EX; then flush kills it.
    idle(); id_valid = 1; id_pc = 32'h200; id_inst = mk(3, 4); ex_ready = 0;
    repeat (3) tick();
    flush = 1;
    tick();
    chk("t5_flush", ex_valid, 1'b0);

    // Reset mid-stream.
    idle(); id_valid = 1; id_pc = 32'h300; id_inst = mk(5, 0);
    tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_ex("t1_rst");
    @(negedge clk);
    rst_n = 1;
    idle(); id_valid = 1; id_inst = mk(5, 0);
    tick();
    chk("t1_x5", ex_rd1, 32'h0);

    // Randomized traffic.
    repeat (600) begin
      rand_in();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
